// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Types and constants shared by the iterative RV32M divider (div_unit) and
// its single-step datapath (div_step).
//   div_op_t    : opE encoding (DIV, DIVU, REM, REMU)
//   div_state_t : divider FSM states
//   DIV_ITERS   : restoring iterations per divide (one per quotient bit)
// -----------------------------------------------------------------------------
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } div_state_t;

    localparam int DIV_ITERS = 32;

    // Signed ops have opE[0] == 0
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on a packed {rem, quot}
// register: shift left by one, trial-subtract the divisor from the upper
// half, keep the difference and set quotient bit 0 when it does not go
// negative.
// Ports:
//   divisor [XLEN-1:0]   in  divisor magnitude
//   rq_in   [2*XLEN-1:0] in  current {rem, quot}
//   rq_out  [2*XLEN-1:0] out next {rem, quot}
// -----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   divisor,
    input  logic [2*XLEN-1:0] rq_in,
    output logic [2*XLEN-1:0] rq_out
);

    // The shifted partial remainder can reach 2*divisor-1, so the trial
    // compare is done at XLEN+1 bits. When it succeeds the difference is
    // below the divisor and fits XLEN bits, so the subtract can be narrow.
    logic [XLEN:0]   shifted_rem;
    logic            ge;
    logic [XLEN-1:0] diff;

    always_comb begin
        shifted_rem = rq_in[2*XLEN-1:XLEN-1];
        ge          = shifted_rem >= {1'b0, divisor};
        diff        = shifted_rem[XLEN-1:0] - divisor;
        if (ge) begin
            rq_out = {diff, rq_in[XLEN-2:0], 1'b1};
        end else begin
            rq_out = {rq_in[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative RV32M divider (DIV, DIVU, REM, REMU) for the execute stage.
// Holds the instruction in E via haltE while iterating one restoring step
// per cycle and presents the result on the DONE (release) cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; haltE = startE & ~flushE, accepts a new op
//   BUSY  | one restoring iteration per cycle, haltE = 1
//   DONE  | sign/special fix-up, doneE = 1, resultE valid, back to IDLE
//
// Ports:
//   clk, reset            in  core clock, synchronous active-high reset
//   startE                in  valid divide op in E
//   opE [1:0]             in  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   srcaE, srcbE [XLEN]   in  dividend, divisor
//   flushE                in  kill the op in E (any state)
//   haltE                 out hold E (combinational)
//   doneE                 out result valid this cycle
//   resultE [XLEN]        out quotient or remainder, 0 when doneE = 0
//
// Build option: DIV_SPECIAL_BYPASS_EN -- when defined, divide-by-zero and
// signed overflow skip the iterations and go IDLE -> DONE directly.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            startE,
    input  logic [1:0]      opE,
    input  logic [XLEN-1:0] srcaE,
    input  logic [XLEN-1:0] srcbE,
    input  logic            flushE,
    output logic            haltE,
    output logic            doneE,
    output logic [XLEN-1:0] resultE
);

    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIV_ITERS - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t        state, state_next;
    div_op_t           op_q;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] rq;
    logic [2*XLEN-1:0] rq_step;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN-1:0]   dividend_q;
    logic              neg_quot_q;
    logic              neg_rem_q;
    logic              div_zero_q;
    logic              ovf_q;

    logic              accept;
    logic              signed_in;
    logic              a_neg, b_neg;
    logic              div_zero_in;
    logic              ovf_in;
    logic [XLEN-1:0]   abs_a, abs_b;

    always_comb begin
        signed_in   = op_is_signed(opE);
        a_neg       = signed_in & srcaE[XLEN-1];
        b_neg       = signed_in & srcbE[XLEN-1];
        abs_a       = a_neg ? -srcaE : srcaE;
        abs_b       = b_neg ? -srcbE : srcbE;
        div_zero_in = (srcbE == '0);
        ovf_in      = signed_in & (srcaE == INT_MIN) & (srcbE == '1);
        accept      = (state == S_IDLE) & startE & ~flushE;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .divisor (divisor_q),
        .rq_in   (rq),
        .rq_out  (rq_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef DIV_SPECIAL_BYPASS_EN
                    state_next = (div_zero_in | ovf_in) ? S_DONE : S_BUSY;
`else
                    state_next = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (count == LAST_COUNT) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flushE) begin
            state_next = S_IDLE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= DIV_OP_DIV;
            count      <= '0;
            rq         <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            op_q       <= div_op_t'(opE);
            count      <= '0;
            rq         <= {{XLEN{1'b0}}, abs_a};
            divisor_q  <= abs_b;
            dividend_q <= srcaE;
            neg_quot_q <= (a_neg ^ b_neg) & ~div_zero_in;
            neg_rem_q  <= a_neg;
            div_zero_q <= div_zero_in;
            ovf_q      <= ovf_in;
        end else if ((state == S_BUSY) && !flushE) begin
            rq    <= rq_step;
            count <= count + 1'b1;
        end
    end

    // Outputs
    logic [XLEN-1:0] quot_fix, rem_fix;
    logic            rem_sel;

    always_comb begin
        quot_fix = neg_quot_q ? -rq[XLEN-1:0] : rq[XLEN-1:0];
        rem_fix  = neg_rem_q ? -rq[2*XLEN-1:XLEN] : rq[2*XLEN-1:XLEN];
        // Special cases are forced explicitly so they do not depend on
        // whether the iterations actually ran.
        if (div_zero_q) begin
            quot_fix = '1;
            rem_fix  = dividend_q;
        end else if (ovf_q) begin
            quot_fix = INT_MIN;
            rem_fix  = '0;
        end
        rem_sel = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);

        haltE   = 1'b0;
        doneE   = 1'b0;
        resultE = '0;
        case (state)
            S_IDLE: haltE = startE & ~flushE;
            S_BUSY: haltE = ~flushE;
            S_DONE: begin
                doneE = ~flushE;
                if (!flushE) begin
                    resultE = rem_sel ? rem_fix : quot_fix;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        flushE;
    logic        haltE, doneE;
    logic [31:0] resultE;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          c0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .startE  (startE),
        .opE     (opE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .flushE  (flushE),
        .haltE   (haltE),
        .doneE   (doneE),
        .resultE (resultE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RISC-V M-extension rules in plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] q, r;
        sgn = (op == 2'b00) || (op == 2'b10);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == 2'b10 || op == 2'b11) ? r : q;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'd0) ||
                  (((op == 2'b00) || (op == 2'b10)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_BYPASS_EN
        return special ? 1 : 33;
`else
        return special ? 33 : 33;
`endif
    endfunction

    // Monitor: pops the scoreboard whenever the DUT releases a result
    always @(negedge clk) begin
        if (reset === 1'b0 && doneE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", resultE, e.res);
                check("latency", 32'(cyc - e.c0), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic halt_ok;
        logic done;
        @(negedge clk);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        e.res  = ref_div(op, a, b);
        e.c0   = cyc;
        e.lat  = ref_lat(op, a, b);
        sb.push_back(e);
        #1;
        halt_ok = (haltE === 1'b1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (doneE === 1'b1) begin
                done = 1'b1;
                if (haltE !== 1'b0) halt_ok = 1'b0;
            end else if (haltE !== 1'b1) begin
                halt_ok = 1'b0;
            end
        end
        check("halt_sequence", {31'd0, halt_ok}, 32'd1);
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1 startE = 1'b0;
    endtask

    task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset  = 1'b1;
        startE = 1'b0;
        opE    = 2'b00;
        srcaE  = '0;
        srcbE  = '0;
        flushE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_halt", {31'd0, haltE}, 32'd0);
        check("reset_done", {31'd0, doneE}, 32'd0);
        check("reset_result", resultE, 32'd0);
        reset = 1'b0;

        // Directed cases (back-to-back)
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op(2'b00, 32'd5, 32'd0);
        run_op(2'b11, 32'd5, 32'd0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1);

        // Flush mid-operation at C10, restart at C11
        start_only(2'b01, 32'd1234567, 32'd89);
        repeat (10) @(negedge clk);
        flushE = 1'b1;
        #1;
        check("flush_halt", {31'd0, haltE}, 32'd0);
        check("flush_done", {31'd0, doneE}, 32'd0);
        @(posedge clk);
        #1;
        flushE = 1'b0;
        startE = 1'b0;
        #1;
        check("flush_idle", {31'd0, haltE}, 32'd0);
        run_op(2'b01, 32'd9, 32'd3);

        // Flush and start in the same IDLE cycle: flush wins
        start_only(2'b00, 32'd50, 32'd5);
        flushE = 1'b1;
        #1;
        check("flush_start_halt", {31'd0, haltE}, 32'd0);
        @(posedge clk);
        #1;
        flushE = 1'b0;
        startE = 1'b0;
        #1;
        check("flush_start_no_busy", {31'd0, haltE}, 32'd0);

        // Flush on the DONE cycle suppresses doneE/resultE
        start_only(2'b01, 32'd77, 32'd3);
        repeat (32) @(posedge clk);
        @(posedge clk);
        #1;
        flushE = 1'b1;
        #1;
        check("flush_in_done_done", {31'd0, doneE}, 32'd0);
        check("flush_in_done_result", resultE, 32'd0);
        @(posedge clk);
        #1;
        flushE = 1'b0;
        startE = 1'b0;
        #1;
        check("flush_in_done_idle", {31'd0, haltE}, 32'd0);

        // Reset at C15 of a divide
        start_only(2'b00, 32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
        #1;
        check("midreset_halt", {31'd0, haltE}, 32'd0);
        check("midreset_done", {31'd0, doneE}, 32'd0);
        check("midreset_result", resultE, 32'd0);
        reset = 1'b0;
        run_op(2'b10, 32'd1000, 32'd3);

        // Randomized ops with occasional special operands
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 300));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(rop, ra, rb);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider (DIV, DIVU, REM, REMU) in the execute stage of the 5-stage core. It accepts an operation from E, holds the instruction in E by driving `haltE` to the hazard unit while it iterates, and presents the result on the release cycle. It obeys `flushE` from the hazard unit, so a mispredicted-path divide is killed mid-operation.

## Interface
- `XLEN`, 32, operand/result width (only 32 supported)
- `clk`  in  1  core clock; all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- `startE`  in  1  valid divide op present in E this cycle
- `opE`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `srcaE`  in  XLEN  dividend (post-forwarding)
- `srcbE`  in  XLEN  divisor (post-forwarding)
- `flushE`  in  1  kill the op in E
- `haltE`  out  1  hold E (to hazard unit); combinational
- `doneE`  out  1  result valid this cycle; instruction leaves E at next edge
- `resultE`  out  XLEN  quotient or remainder per `opE`

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `haltE = startE & ~flushE`. On `startE & ~flushE`:
  - latch op, |dividend|, |divisor| (signed ops) or raw values (unsigned);
  - latch sign flags;
  - count = 0;
  - go to BUSY.
- BUSY: one restoring step per cycle on a 64-bit {rem, quot} register:
  - shift left 1;
  - trial subtract the divisor from the upper half; if non-negative, keep it and set quot bit 0.
  - count++. After step 32 (count = 31 at edge), go to DONE. `haltE = 1`.
- DONE: `haltE = 0`, `doneE = 1`, `resultE` driven from the final registers. Go to IDLE unconditionally. `startE` is still high in DONE and must not restart.
- Sign fix in DONE:
  - quotient negated if dividend and divisor signs differ and divisor ≠ 0;
  - remainder takes the dividend's sign.
- Divide by zero:
  - quotient = 32'hFFFF_FFFF (all ops);
  - remainder = dividend unchanged.
- Signed overflow (32'h8000_0000 / 32'hFFFF_FFFF):
  - quotient = 32'h8000_0000;
  - remainder = 0.
- Unsigned arithmetic is 33-bit for the trial subtract. Result truncated to XLEN.
- `flushE` in any state: next state IDLE, `haltE = 0` and `doneE = 0` that same cycle. Partial state is discarded.
- `resultE` = 0 whenever `doneE = 0`.

## Timing
- Reset: state IDLE, count 0, `haltE` 0, `doneE` 0, `resultE` 0, datapath regs 0. Reset mid-BUSY behaves identically.
- Normal latency: start cycle C0 and BUSY C1..C32 all have `haltE = 1`. DONE is C33 (`doneE = 1`, `haltE = 0`). The instruction spends 34 cycles in E.
- `haltE` depends combinationally on `startE`/`flushE` in IDLE. There is no registered path from inputs to `haltE`.
- Flush and start in the same cycle: the flush wins, with no start.
- Flush in DONE: `doneE` is suppressed and the state goes to IDLE.
- Back-to-back divides: the second `startE` is accepted in the IDLE cycle that follows DONE.

## Configuration
- `DIV_SPECIAL_BYPASS_EN` defined:
  - divide-by-zero and signed overflow are detected in C0;
  - the unit goes IDLE → DONE directly;
  - `haltE = 1` in C0 only, and the result appears in C1.
- Not defined:
  - special cases run all 32 iterations;
  - the DONE-stage fix-up still forces the architectural values above;
  - latency is always 34 cycles.

## Structure
- Shared core package holds:
  - `div_op_t` enum (DIV, DIVU, REM, REMU);
  - `div_state_t` enum;
  - `DIV_ITERS = 32`.
- Sub-module `div_step`: combinational single restoring iteration ({rem, quot}, divisor in; next {rem, quot} out). The FSM and count live in `div_unit`.

## Test plan
- DIVU 100 / 7:
  - `haltE` high in C0–C32;
  - C33 `doneE = 1`, `resultE = 14`.
  - REMU on the same operands gives 2.
- DIV −7 / 2 gives −3 (32'hFFFF_FFFD). REM −7 / 2 gives −1. REM 7 / −2 gives 1.
- DIV 5 / 0 gives 32'hFFFF_FFFF. REMU 5 / 0 gives 5.
  - Latency is 2 cycles with `DIV_SPECIAL_BYPASS_EN` and 34 without.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF gives 32'h8000_0000. REM gives 0.
- Flush and restart:
  - start DIVU, assert `flushE` at C10 → `haltE = 0` at C10 and IDLE at C11;
  - new DIVU 9 / 3 started at C11 → 3 at C44.
- Reset and restart:
  - assert `reset` at C15 of a divide → all outputs 0 next cycle;
  - the next start completes normally.
